serial_receiver: RTL and testbench
==================================

// Module: serial_receiver
// PURPOSE
//  Receive end of the chunked serial link: collects 32/LENGTH chunks of LENGTH bits, first chunk = MSBs.
//  Reassembles them into one 32-bit word and presents it to the calculator datapath with a done strobe.
//  Single clock domain; chunk strobe rxValid arrives already synchronous to clk.
// PARAMETERS
//  LENGTH      4    chunk width in bits; must divide 32 (elaboration $error otherwise)
//  TIMEOUT     64   idle cycles allowed between chunks (used only with SERIAL_RX_TIMEOUT_EN)
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  reset      in   1        synchronous, active-high reset
//  startRx    in   1        arm receiver for a new word (honoured in IDLE only)
//  rxValid    in   1        din holds a valid chunk this cycle
//  din        in   LENGTH   serial chunk, MSB-first order across the word
//  rxBusy     out  1        high while a word is being assembled
//  rxDone     out  1        one-cycle pulse: dout just updated with a complete word
//  dout       out  32       last completed word; held until the next word completes
//  rxTimeout  out  1        (SERIAL_RX_TIMEOUT_EN only) one-cycle pulse on frame abort
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, shift reg=0, chunk count=0, dout=0, rxBusy=0, rxDone=0, rxTimeout=0.
//  Reset mid-frame discards the partial word; dout returns to 0.
//  NUM_CHUNKS = 32/LENGTH; count register width = $clog2(NUM_CHUNKS+1).
//  FSM states IDLE, RECV, DONE; all outputs registered.
//  IDLE: rxValid ignored. startRx=1 -> RECV next cycle; shift reg cleared, count=0, rxBusy=1.
//    startRx and rxValid in the same IDLE cycle: arm only, that chunk is discarded.
//  RECV: each cycle with rxValid=1: shift <= {shift[31-LENGTH:0], din}, count++.
//    startRx ignored. rxValid=0 cycles are allowed (gaps), state holds.
//    On the cycle the NUM_CHUNKS-th chunk is sampled: next cycle dout = assembled word,
//    rxDone=1, rxBusy=0, state=DONE. Latency: last chunk -> rxDone = 1 cycle.
//  DONE: single cycle; rxDone drops, -> IDLE. rxValid/startRx in DONE ignored.
//  Back-to-back words: startRx may be asserted in the first IDLE cycle after DONE.
//  Chunk order: chunk k (k=0..NUM_CHUNKS-1) lands in dout[31-k*LENGTH -: LENGTH].
// CONFIGURATION
//  SERIAL_RX_TIMEOUT_EN defined: idle counter in RECV, cleared on entry and on each rxValid.
//    Reaching TIMEOUT cycles with no chunk -> IDLE next cycle, rxTimeout=1 for one cycle,
//    rxBusy=0, rxDone stays 0, dout keeps previous word. A chunk on the TIMEOUT-th cycle is accepted (no abort).
//  SERIAL_RX_TIMEOUT_EN undefined: no rxTimeout port, no idle counter; RECV waits indefinitely.
// STRUCTURE
//  serial_pkg: WORD_WIDTH=32, typedef enum logic [1:0] {IDLE,RECV,DONE} rx_state_t,
//    function num_chunks(LENGTH) shared with the transmit side.
//  One sub-module: serial_rx_shifter (LENGTH-bit shift-in register + chunk counter, full flag).
//  Top holds the FSM, output registers and the optional timeout counter.
// TESTING
//  LENGTH=4: startRx, chunks D,E,A,D,B,E,E,F with random gaps -> dout=32'hDEADBEEF, rxDone 1 cycle, 1 cycle after 8th chunk.
//  LENGTH=8: back-to-back 12,34,56,78 then immediate second word 9A,BC,DE,F0 -> 32'h12345678 then 32'h9ABCDEF0.
//  rxValid pulses in IDLE, and startRx+rxValid same cycle -> chunks ignored, next word assembles correctly.
//  3 chunks then reset=1 one cycle -> dout=0, rxBusy=0; following full word received correctly.
//  startRx re-asserted mid-RECV -> no restart; word completes with correct value.
//  TIMEOUT_EN, TIMEOUT=16: 3 chunks then 16 idle cycles -> rxTimeout pulse, dout keeps prior word, rxDone never high.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the chunked serial link (receive and transmit sides).
//   WORD_WIDTH  : width of one reassembled word
//   rx_state_t  : receiver FSM encoding
//   num_chunks  : chunks per word for a given chunk width
package serial_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_t;

  function automatic int num_chunks(input int len);
    return WORD_WIDTH / len;
  endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// Shift-in register and chunk counter for the serial receiver.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   clr        : clear register and counter (start of a new word)
//   en         : shift din in and count one chunk
//   din        : LENGTH-bit chunk
//   shift_nxt  : word including the chunk being sampled this cycle
//   last       : the chunk sampled this cycle completes the word
module serial_rx_shifter
  import serial_pkg::*;
#(
  parameter int LENGTH     = 4,
  parameter int NUM_CHUNKS = num_chunks(LENGTH),
  parameter int CW         = $clog2(NUM_CHUNKS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [LENGTH-1:0]     din,
  output logic [WORD_WIDTH-1:0] shift_nxt,
  output logic                  last
);

  logic [WORD_WIDTH-1:0] shift;
  logic [CW-1:0]         count;

  // A single full-width chunk replaces the register outright.
  generate
    if (LENGTH == WORD_WIDTH) begin : g_whole
      assign shift_nxt = din;
    end else begin : g_shift
      assign shift_nxt = {shift[WORD_WIDTH-LENGTH-1:0], din};
    end
  endgenerate

  assign last = en && (count == CW'(NUM_CHUNKS - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      shift <= '0;
      count <= '0;
    end else if (en) begin
      shift <= shift_nxt;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// Receive end of the chunked serial link. Collects WORD_WIDTH/LENGTH chunks
// (first chunk = MSBs), presents the reassembled word on dout with a
// one-cycle rxDone strobe. All outputs registered.
// Optional feature macro: SERIAL_RX_TIMEOUT_EN -- aborts a frame after
// TIMEOUT idle cycles in RECV and pulses rxTimeout.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   startRx    : arm for a new word (IDLE only)
//   rxValid    : din holds a valid chunk
//   din        : LENGTH-bit chunk
//   rxBusy     : word being assembled
//   rxDone     : dout just updated with a complete word
//   dout       : last completed word
//   rxTimeout  : frame aborted (SERIAL_RX_TIMEOUT_EN only)
module serial_receiver
  import serial_pkg::*;
#(
  parameter int LENGTH  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startRx,
  input  logic                  rxValid,
  input  logic [LENGTH-1:0]     din,
  output logic                  rxBusy,
  output logic                  rxDone,
`ifdef SERIAL_RX_TIMEOUT_EN
  output logic                  rxTimeout,
`endif
  output logic [WORD_WIDTH-1:0] dout
);

  generate
    if (WORD_WIDTH % LENGTH != 0) begin : g_bad_len
      $error("serial_receiver: LENGTH must divide 32");
    end
    if (TIMEOUT < 1) begin : g_bad_tmo
      $error("serial_receiver: TIMEOUT must be at least 1");
    end
  endgenerate

  rx_state_t             state, state_nxt;
  logic                  clr, en, last;
  logic                  busy_nxt, done_nxt, dout_ld;
  logic [WORD_WIDTH-1:0] shift_nxt;

  assign en = (state == RECV) && rxValid;

  serial_rx_shifter #(.LENGTH(LENGTH)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .en        (en),
    .din       (din),
    .shift_nxt (shift_nxt),
    .last      (last)
  );

`ifdef SERIAL_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          tmo_hit, tmo_nxt;

  // Counts consecutive chunk-less RECV cycles; abort is decided on the
  // TIMEOUT-th such cycle, so a chunk arriving on that cycle still wins.
  assign tmo_hit = (state == RECV) && !rxValid && (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || state != RECV || rxValid) idle_cnt <= '0;
    else                                   idle_cnt <= idle_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    busy_nxt  = rxBusy;
    done_nxt  = 1'b0;
    dout_ld   = 1'b0;
`ifdef SERIAL_RX_TIMEOUT_EN
    tmo_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        // A chunk arriving with startRx is dropped: en is low in IDLE.
        if (startRx) begin
          state_nxt = RECV;
          clr       = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      RECV: begin
        if (last) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          dout_ld   = 1'b1;
        end
`ifdef SERIAL_RX_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          tmo_nxt   = 1'b1;
        end
`endif
      end
      DONE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rxBusy <= 1'b0;
      rxDone <= 1'b0;
      dout   <= '0;
`ifdef SERIAL_RX_TIMEOUT_EN
      rxTimeout <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      rxBusy <= busy_nxt;
      rxDone <= done_nxt;
      if (dout_ld) dout <= shift_nxt;
`ifdef SERIAL_RX_TIMEOUT_EN
      rxTimeout <= tmo_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: one LENGTH=4 instance (TIMEOUT=16)
// and one LENGTH=8 instance, each with its own control signals.
module tb_serial_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r4, s4, v4;
  logic [3:0]  d4;
  logic        busy4, done4;
  logic [31:0] dout4;
  logic        r8, s8, v8;
  logic [7:0]  d8;
  logic        busy8, done8;
  logic [31:0] dout8;
`ifdef SERIAL_RX_TIMEOUT_EN
  logic        tmo4, tmo8;
`endif

  int tests = 0;
  int fails = 0;

  serial_receiver #(.LENGTH(4), .TIMEOUT(16)) u4 (
    .clk(clk), .reset(r4), .startRx(s4), .rxValid(v4), .din(d4),
    .rxBusy(busy4), .rxDone(done4),
`ifdef SERIAL_RX_TIMEOUT_EN
    .rxTimeout(tmo4),
`endif
    .dout(dout4)
  );

  serial_receiver #(.LENGTH(8)) u8 (
    .clk(clk), .reset(r8), .startRx(s8), .rxValid(v8), .din(d8),
    .rxBusy(busy8), .rxDone(done8),
`ifdef SERIAL_RX_TIMEOUT_EN
    .rxTimeout(tmo8),
`endif
    .dout(dout8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start4();
    s4 = 1'b1; tick(); s4 = 1'b0;
    chk("start4_busy", {31'd0, busy4}, 32'd1);
  endtask

  task automatic start8();
    s8 = 1'b1; tick(); s8 = 1'b0;
    chk("start8_busy", {31'd0, busy8}, 32'd1);
  endtask

  task automatic send4(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, maxgap)) tick();
      v4 = 1'b1; d4 = w[31-4*k -: 4];
      tick();
      v4 = 1'b0;
      if (k == 6) chk("send4_nodone_early", {30'd0, busy4, done4}, 32'd2);
    end
  endtask

  task automatic send8(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      v8 = 1'b1; d8 = w[31-8*k -: 8];
      tick();
    end
    v8 = 1'b0;
  endtask

  initial begin
    r4 = 1'b1; s4 = 1'b0; v4 = 1'b0; d4 = '0;
    r8 = 1'b1; s8 = 1'b0; v8 = 1'b0; d8 = '0;
    tick(); tick();
    chk("rst4_out", {dout4[31:2], busy4, done4}, 32'd0);
    chk("rst4_dout", dout4, 32'd0);
    chk("rst8_dout", dout8, 32'd0);
    chk("rst8_flags", {30'd0, busy8, done8}, 32'd0);
    r4 = 1'b0; r8 = 1'b0;
    tick();

    // LENGTH=4 word with random gaps.
    start4();
    send4(32'hDEADBEEF, 3);
    chk("l4_done", {31'd0, done4}, 32'd1);
    chk("l4_busy", {31'd0, busy4}, 32'd0);
    chk("l4_dout", dout4, 32'hDEADBEEF);
    tick();
    chk("l4_done_pulse", {31'd0, done4}, 32'd0);
    chk("l4_dout_hold", dout4, 32'hDEADBEEF);

    // LENGTH=8 back-to-back words.
    start8();
    send8(32'h12345678);
    chk("b2b_done1", {31'd0, done8}, 32'd1);
    chk("b2b_dout1", dout8, 32'h12345678);
    tick();
    chk("b2b_done1_pulse", {31'd0, done8}, 32'd0);
    start8();
    send8(32'h9ABCDEF0);
    chk("b2b_done2", {31'd0, done8}, 32'd1);
    chk("b2b_dout2", dout8, 32'h9ABCDEF0);
    tick();

    // rxValid in IDLE ignored; startRx+rxValid arms only.
    v8 = 1'b1; d8 = 8'hFF;
    repeat (3) tick();
    chk("idle_valid_busy", {31'd0, busy8}, 32'd0);
    chk("idle_valid_dout", dout8, 32'h9ABCDEF0);
    s8 = 1'b1; d8 = 8'hAA;
    tick();
    s8 = 1'b0; v8 = 1'b0;
    chk("arm_busy", {31'd0, busy8}, 32'd1);
    send8(32'h11223344);
    chk("arm_done", {31'd0, done8}, 32'd1);
    chk("arm_dout", dout8, 32'h11223344);
    tick();

    // Reset mid-frame discards the partial word.
    start4();
    for (int k = 0; k < 3; k++) begin
      v4 = 1'b1; d4 = 4'h5; tick();
    end
    v4 = 1'b0; r4 = 1'b1;
    tick();
    r4 = 1'b0;
    chk("midrst_dout", dout4, 32'd0);
    chk("midrst_busy", {31'd0, busy4}, 32'd0);
    start4();
    send4(32'hCAFEF00D, 2);
    chk("postrst_done", {31'd0, done4}, 32'd1);
    chk("postrst_dout", dout4, 32'hCAFEF00D);
    tick();

    // startRx during RECV does not restart the word.
    start8();
    v8 = 1'b1; d8 = 8'hA1; tick();
    d8 = 8'hB2; tick();
    s8 = 1'b1; d8 = 8'hC3; tick();
    v8 = 1'b0; tick();
    chk("restart_busy", {31'd0, busy8}, 32'd1);
    s8 = 1'b0; v8 = 1'b1; d8 = 8'hD4; tick();
    v8 = 1'b0;
    chk("restart_done", {31'd0, done8}, 32'd1);
    chk("restart_dout", dout8, 32'hA1B2C3D4);
    tick();

`ifdef SERIAL_RX_TIMEOUT_EN
    // 3 chunks then 16 idle cycles -> abort.
    begin
      logic seen_done;
      seen_done = 1'b0;
      start4();
      for (int k = 0; k < 3; k++) begin
        v4 = 1'b1; d4 = 4'h7; tick();
      end
      v4 = 1'b0;
      for (int n = 1; n <= 15; n++) begin
        tick();
        seen_done |= done4;
        if (n == 15) chk("tmo_not_early", {31'd0, tmo4}, 32'd0);
      end
      tick();
      chk("tmo_pulse", {31'd0, tmo4}, 32'd1);
      chk("tmo_busy", {31'd0, busy4}, 32'd0);
      chk("tmo_dout_kept", dout4, 32'hCAFEF00D);
      tick();
      seen_done |= done4;
      chk("tmo_pulse_end", {31'd0, tmo4}, 32'd0);
      chk("tmo_no_done", {31'd0, seen_done}, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
